flag_unit: RTL

- Consumer end of the ID-stage controller's status-update output (S).
- Owns the NZCV status register and tracks in-flight flag-setting instructions between ID and the flag-write stage.
- Evaluates the ARM condition field of the instruction in ID.
- Raises a flag-hazard stall when that instruction depends on flags that have not yet been written.

---
 rtl/arm_pkg.sv | 30 +++
 rtl/flag_unit_cond_eval.sv | 43 ++++
 rtl/flag_unit.sv | 82 ++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared ARM status definitions: NZCV layout and condition-field encodings.
// Used by the flag unit and the condition evaluator.
package arm_pkg;

  typedef logic [3:0] nzcv_t;
  typedef logic [3:0] cond_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam cond_t COND_EQ = 4'h0;
  localparam cond_t COND_NE = 4'h1;
  localparam cond_t COND_CS = 4'h2;
  localparam cond_t COND_CC = 4'h3;
  localparam cond_t COND_MI = 4'h4;
  localparam cond_t COND_PL = 4'h5;
  localparam cond_t COND_VS = 4'h6;
  localparam cond_t COND_VC = 4'h7;
  localparam cond_t COND_HI = 4'h8;
  localparam cond_t COND_LS = 4'h9;
  localparam cond_t COND_GE = 4'hA;
  localparam cond_t COND_LT = 4'hB;
  localparam cond_t COND_GT = 4'hC;
  localparam cond_t COND_LE = 4'hD;
  localparam cond_t COND_AL = 4'hE;
  localparam cond_t COND_NV = 4'hF;

endpackage

// File: rtl/flag_unit_cond_eval.sv
// Combinational ARM condition evaluator: cond field + NZCV -> pass.
// Shared with the branch unit.
module cond_eval
  import arm_pkg::*;
(
  input  cond_t i_cond,
  input  nzcv_t i_nzcv,
  output logic  o_pass
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_n = i_nzcv[FLAG_N];
  assign w_z = i_nzcv[FLAG_Z];
  assign w_c = i_nzcv[FLAG_C];
  assign w_v = i_nzcv[FLAG_V];

  always_comb begin
    o_pass = 1'b0;
    unique case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = ~w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = ~w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = ~w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = ~w_v;
      COND_HI: o_pass = w_c & ~w_z;
      COND_LS: o_pass = ~w_c | w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = ~w_z & (w_n == w_v);
      COND_LE: o_pass = w_z | (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      COND_NV: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// NZCV status register, in-flight flag-write tracking and flag-hazard stall.
// Define FLAG_FWD_EN to forward alu_nzcv from the flag-write stage.
module flag_unit
  import arm_pkg::*;
#(
  parameter int PIPE_DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       freeze,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  input  logic       id_s,
  input  logic       id_flush,
  input  logic [3:0] alu_nzcv,
  output logic [3:0] status,
  output logic       cond_pass,
  output logic       flag_hazard
);

  localparam int TOP = PIPE_DEPTH - 1;

  logic [PIPE_DEPTH-1:0] r_pend;
  logic [PIPE_DEPTH-1:0] w_pend_nxt;
  logic [PIPE_DEPTH-1:0] w_pend_vis;
  nzcv_t                 r_status;
  nzcv_t                 w_flags;
  logic                  w_retire;
  logic                  w_issue;
  logic                  w_hazard;
  logic                  w_pass;

  assign w_retire = r_pend[TOP];
  assign w_issue  = id_valid & id_s & ~id_flush & ~w_hazard;

  generate
    if (PIPE_DEPTH == 1) begin : g_d1
      assign w_pend_nxt = w_issue;
    end else begin : g_dn
      assign w_pend_nxt = {r_pend[PIPE_DEPTH-2:0], w_issue};
    end
  endgenerate

`ifdef FLAG_FWD_EN
  // The retiring write is visible via alu_nzcv, so it cannot cause a stall.
  always_comb begin
    w_pend_vis      = r_pend;
    w_pend_vis[TOP] = 1'b0;
  end
  assign w_flags = w_retire ? alu_nzcv : r_status;
`else
  assign w_pend_vis = r_pend;
  assign w_flags    = r_status;
`endif

  assign w_hazard = id_valid & ~id_flush &
                    (id_cond != COND_AL) &
                    (|w_pend_vis);

  cond_eval u_cond_eval (
    .i_cond (id_cond),
    .i_nzcv (w_flags),
    .o_pass (w_pass)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend   <= '0;
      r_status <= '0;
    end else if (!freeze) begin
      r_pend <= w_pend_nxt;
      if (w_retire) begin
        r_status <= alu_nzcv;
      end
    end
  end

  assign status      = r_status;
  assign cond_pass   = w_pass;
  assign flag_hazard = w_hazard;

endmodule
